// File: rtl/fp16_mac_pkg.sv
// Shared definitions for the float MAC: operand width, fp16 constants and
// elaboration-time width helpers.
package fp16_mac_pkg;

  localparam int unsigned FP16_W = 16;

  localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;
  localparam logic [FP16_W-1:0] FP16_TWO = 16'h4000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idw(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/fp16_mul_arbiter_rr.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping,
// reported both one-hot and as an index.
module rr_arbiter
  import fp16_mac_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    logic [IDW-1:0] cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one pipelined fp16 multiplier among NREQ requesters; results return
// in issue order through a credit-protected FIFO tagged with requester id.
module fp16_mul_arbiter
  import fp16_mac_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned MUL_LAT = 1,
  parameter  int unsigned RBUF    = 4,
  localparam int unsigned IDW     = idw(NREQ)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FP16_W-1:0]   req_a,
  input  logic [NREQ*FP16_W-1:0]   req_b,
  output logic [FP16_W-1:0]        mul_a,
  output logic [FP16_W-1:0]        mul_b,
  input  logic [FP16_W-1:0]        mul_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FP16_W-1:0]        rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     busy
);

  localparam int unsigned PW = idw(RBUF);
  localparam int unsigned CW = clog2(RBUF + 1);

  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic              gnt_any;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     count;
  logic [FP16_W-1:0] mul_a_q;
  logic [FP16_W-1:0] mul_b_q;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDW-1:0]    tag_id   [MUL_LAT];
  logic [FP16_W-1:0] fifo_data[RBUF];
  logic [IDW-1:0]    fifo_id  [RBUF];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Operands pass straight through on an issue cycle so the multiplier's own
  // register provides the MUL_LAT stages; otherwise the last pair is held.
  always_comb begin
    issue     = !RESET && (credits != '0) && gnt_any;
    req_ready = issue ? gnt : '0;
    mul_a     = issue ? req_a[gnt_idx*FP16_W +: FP16_W] : mul_a_q;
    mul_b     = issue ? req_b[gnt_idx*FP16_W +: FP16_W] : mul_b_q;
    push      = tag_v[MUL_LAT-1];
    rsp_valid = (count != '0);
    pop       = rsp_valid && rsp_ready;
    rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
    rsp_id    = rsp_valid ? fifo_id[rd_ptr] : '0;
    busy      = (|tag_v) || rsp_valid;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr  <= '0;
      credits <= CW'(RBUF);
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      tag_v   <= '0;
    end else begin
      if (issue) begin
        rr_ptr  <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        mul_a_q <= mul_a;
        mul_b_q <= mul_b;
      end
      tag_v[0] <= issue;
      for (int unsigned i = 1; i < MUL_LAT; i++) tag_v[i] <= tag_v[i-1];
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push) wr_ptr <= (wr_ptr == PW'(RBUF - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(RBUF - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Ids and storage need no reset: validity lives in tag_v and count.
  always_ff @(posedge CLK) begin
    tag_id[0] <= gnt_idx;
    for (int unsigned i = 1; i < MUL_LAT; i++) tag_id[i] <= tag_id[i-1];
    if (push) begin
      fifo_data[wr_ptr] <= mul_out;
      fifo_id[wr_ptr]   <= tag_id[MUL_LAT-1];
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Bench for fp16_mul_arbiter: directed table and sequences plus random traffic,
// all checked against a transaction-level model of grants and result order.
module tb_fp16_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 1;
  localparam int RBUF    = 4;
  localparam int IDW     = 2;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a = '0;
  logic [NREQ*16-1:0] req_b = '0;
  logic [15:0]        mul_a, mul_b, mul_out, rsp_data;
  logic               rsp_valid, busy;
  logic               rsp_ready = 1'b0;
  logic [IDW-1:0]     rsp_id;

  int checks = 0;
  int errors = 0;

  fp16_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .RBUF(RBUF)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  // Stand-in multiplier: exact for x*1.0, a fixed scramble otherwise.
  function automatic logic [15:0] tb_mul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00) return b;
    if (b == 16'h3C00) return a;
    return (a * 16'd3) ^ {b[7:0], b[15:8]} ^ 16'h1234;
  endfunction

  logic [15:0] mpipe [MUL_LAT];
  always @(posedge CLK) begin
    mpipe[0] <= tb_mul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_out = mpipe[MUL_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h3C00 : 16'($urandom);
      req_b[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'h3C00 : 16'($urandom);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    nxt();
    nxt();
    RESET = 1'b0;
  endtask

  // Transaction model: every accepted op is outstanding until popped; credits
  // are what is left of RBUF, and each op becomes visible MUL_LAT+1 cycles on.
  typedef struct { logic [15:0] data; int id; int due; } ent_t;
  ent_t mq[$];
  int   mptr  = 0;
  int   mcyc  = 0;
  bit   armed = 1'b0;

  always @(negedge CLK) begin
    int          g;
    int          j;
    logic [3:0]  er;
    bit          ev;
    ent_t        e;
    if (RESET) begin
      mq.delete();
      mptr = 0;
      if (armed) check("mon_reset_ready", 32'(req_ready), 32'h0);
    end else begin
      armed = 1'b1;
      g = -1;
      if (RBUF - mq.size() > 0) begin
        for (int i = 0; i < NREQ; i++) begin
          j = (mptr + i) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
      end
      er = (g >= 0) ? 4'(1 << g) : 4'b0;
      check("mon_req_ready", 32'(req_ready), 32'(er));
      ev = (mq.size() > 0) && (mq[0].due <= mcyc);
      check("mon_rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        check("mon_rsp_data", 32'(rsp_data), 32'(mq[0].data));
        check("mon_rsp_id", 32'(rsp_id), 32'(mq[0].id));
      end
      check("mon_busy", 32'(busy), 32'(mq.size() > 0));
      if (ev && rsp_ready) void'(mq.pop_front());
      if (g >= 0) begin
        e.data = tb_mul(req_a[g*16 +: 16], req_b[g*16 +: 16]);
        e.id   = g;
        e.due  = mcyc + MUL_LAT + 1;
        mq.push_back(e);
        mptr = (g + 1) % NREQ;
      end
    end
    mcyc++;
  end

  typedef struct { logic [3:0] valid; logic [3:0] exp_ready; } vec_t;

  initial begin
    vec_t        tbl [11];
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          acc;

    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b0010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b1010, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0101, 4'b0100};
    tbl[10] = '{4'b0101, 4'b0001};

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", 32'(rsp_data), 32'h0);
    check("reset_rsp_id", 32'(rsp_id), 32'h0);
    check("reset_mul_a", 32'(mul_a), 32'h0);
    check("reset_mul_b", 32'(mul_b), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);

    // Single op: 1.0 * 2.0, visible exactly MUL_LAT+1 cycles after accept.
    nxt();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[15:0] = 16'h3C00;
    req_b[15:0] = 16'h4000;
    @(negedge CLK);
    check("t1_ready", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    for (int k = 1; k <= MUL_LAT + 1; k++) begin
      @(negedge CLK);
      check("t1_rsp_valid", 32'(rsp_valid), 32'(k == MUL_LAT + 1));
      if (k == MUL_LAT + 1) begin
        check("t1_rsp_data", 32'(rsp_data), 32'h4000);
        check("t1_rsp_id", 32'(rsp_id), 32'h0);
      end
      nxt();
    end

    // Grant table from a fresh pointer.
    do_reset();
    for (int t = 0; t < 11; t++) begin
      req_valid = tbl[t].valid;
      rand_ops();
      @(negedge CLK);
      check("tbl_req_ready", 32'(req_ready), 32'(tbl[t].exp_ready));
      nxt();
    end
    req_valid = '0;
    repeat (6) nxt();

    // Backpressure: exactly RBUF accepts, then drain while still requesting.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    acc = 0;
    for (int k = 0; k < RBUF + 3; k++) begin
      rand_ops();
      @(negedge CLK);
      if (req_ready[0]) begin
        acc++;
        exp_q.push_back(tb_mul(req_a[15:0], req_b[15:0]));
      end
      nxt();
    end
    check("t3_accepts", 32'(acc), 32'(RBUF));
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      @(negedge CLK);
      check("t4_req_ready", 32'(req_ready), (k == 0) ? 32'h0 : 32'h1);
      if (rsp_valid) got_q.push_back(rsp_data);
      nxt();
    end
    for (int k = 0; k < RBUF; k++) begin
      check("t3_order", 32'(got_q[k]), 32'(exp_q[k]));
    end
    req_valid = '0;
    repeat (6) nxt();

    // Reset one cycle after an accept discards the op.
    req_valid = 4'b0010;
    rand_ops();
    @(negedge CLK);
    check("t5_accept", 32'(req_ready), 32'h2);
    nxt();
    req_valid = '0;
    RESET = 1'b1;
    nxt();
    RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
      nxt();
    end
    req_valid = 4'b1010;
    @(negedge CLK);
    check("t5_grant", 32'(req_ready), 32'h2);
    nxt();
    req_valid = '0;
    repeat (4) nxt();

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      req_valid = 4'($urandom);
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      nxt();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (12) nxt();
    @(negedge CLK);
    check("final_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
